// File: rtl/hazard_pkg.sv
// Shared hazard encodings for the RV32I pipeline scheduler.
// CtrlUnit produces hazard_optype with the same op-class encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    OPT_NONE  = 2'd0,
    OPT_ALU   = 2'd1,
    OPT_LOAD  = 2'd2,
    OPT_STORE = 2'd3
  } opt_e;

  typedef enum logic [1:0] {
    FWD_RF     = 2'd0,
    FWD_EX     = 2'd1,
    FWD_MEM_ALU = 2'd2,
    FWD_MEM_LD = 2'd3
  } fwd_e;

  function automatic logic opt_writes(input logic [1:0] opt);
    return (opt == OPT_ALU) || (opt == OPT_LOAD);
  endfunction

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Priority forwarding-source select for one ID-stage operand.
// A load still in EX is not a source; the stall logic covers it.
module hazard_fwd_mux_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OPT_W  = 2
) (
  input  logic              use_op,
  input  logic [REG_AW-1:0] rs,
  input  logic [OPT_W-1:0]  opt_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic [OPT_W-1:0]  opt_mem,
  input  logic [REG_AW-1:0] rd_mem,
  output logic [1:0]        sel
);

  logic rs_live;
  logic ex_alu;
  logic mem_alu;
  logic mem_ld;

  assign rs_live = use_op && (rs != '0);
  assign ex_alu  = rs_live && (opt_ex == OPT_ALU) && (rd_ex == rs);
  assign mem_alu = rs_live && (opt_mem == OPT_ALU) && (rd_mem == rs);
  assign mem_ld  = rs_live && (opt_mem == OPT_LOAD) && (rd_mem == rs);

  always_comb begin
    sel = FWD_RF;
    if (ex_alu)
      sel = FWD_EX;
    else if (mem_alu)
      sel = FWD_MEM_ALU;
    else if (mem_ld)
      sel = FWD_MEM_LD;
  end

endmodule

// File: rtl/hazard_sched_unit.sv
// Hazard scheduler: forwarding, load-use stall, branch flush, stage enables.
// Keeps {optype, rd} shadows of EX and MEM plus the load-to-store flag.
module hazard_sched_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int OPT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_busy,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic [OPT_W-1:0]  hazard_optype_ID,
  input  logic              Branch_ID,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic              reg_EM_EN,
  output logic              reg_MW_EN
);

  logic [OPT_W-1:0]  opt_ex;
  logic [OPT_W-1:0]  opt_mem;
  logic [REG_AW-1:0] rd_ex;
  logic [REG_AW-1:0] rd_mem;
  logic              ls_fwd;
  logic              ls_fwd_mem;

  logic [REG_AW-1:0] rd_id_eff;
  logic              ex_ld_live;
  logic              rs1_ex_hit;
  logic              rs2_ex_hit;
  logic              id_store;
  logic              stall;
  logic              freeze;
  logic              ls_set;

  assign rd_id_eff  = opt_writes(hazard_optype_ID) ? rd_ID : '0;
  assign ex_ld_live = (opt_ex == OPT_LOAD) && (rd_ex != '0);
  assign rs1_ex_hit = rs1use_ID && (rs1_ID == rd_ex);
  assign rs2_ex_hit = rs2use_ID && (rs2_ID == rd_ex);
  assign id_store   = hazard_optype_ID == OPT_STORE;
  assign freeze     = mem_busy;

  // Store data from a load in EX is patched in MEM instead of stalling.
  assign stall  = ex_ld_live && (rs1_ex_hit || (rs2_ex_hit && !id_store));
  assign ls_set = !stall && id_store && ex_ld_live && rs2_ex_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opt_ex     <= OPT_NONE;
      rd_ex      <= '0;
      opt_mem    <= OPT_NONE;
      rd_mem     <= '0;
      ls_fwd     <= 1'b0;
      ls_fwd_mem <= 1'b0;
    end else if (!freeze) begin
      opt_mem    <= opt_ex;
      rd_mem     <= rd_ex;
      ls_fwd_mem <= ls_fwd;
      ls_fwd     <= ls_set;
      if (stall) begin
        opt_ex <= OPT_NONE;
        rd_ex  <= '0;
      end else begin
        opt_ex <= hazard_optype_ID;
        rd_ex  <= rd_id_eff;
      end
    end
  end

  hazard_fwd_mux_sel #(
    .REG_AW (REG_AW),
    .OPT_W  (OPT_W)
  ) u_fwd_a (
    .use_op  (rs1use_ID),
    .rs      (rs1_ID),
    .opt_ex  (opt_ex),
    .rd_ex   (rd_ex),
    .opt_mem (opt_mem),
    .rd_mem  (rd_mem),
    .sel     (forward_ctrl_A)
  );

  hazard_fwd_mux_sel #(
    .REG_AW (REG_AW),
    .OPT_W  (OPT_W)
  ) u_fwd_b (
    .use_op  (rs2use_ID),
    .rs      (rs2_ID),
    .opt_ex  (opt_ex),
    .rd_ex   (rd_ex),
    .opt_mem (opt_mem),
    .rd_mem  (rd_mem),
    .sel     (forward_ctrl_B)
  );

  assign forward_ctrl_ls = ls_fwd_mem;

  // Branch is re-evaluated after the stall, so it cannot flush now.
  always_comb begin
    PC_EN_IF     = !stall && !freeze;
    reg_FD_EN    = !stall && !freeze;
    reg_DE_flush = stall && !freeze;
    reg_FD_flush = Branch_ID && !stall && !freeze;
    reg_EM_EN    = !freeze;
    reg_MW_EN    = !freeze;
  end

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Self-checking bench for hazard_sched_unit: directed table,
// freeze/reset sequences and random traffic against a stage model.
module tb_hazard_sched_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_busy = 1'b0;
  logic       rs1use_ID = 1'b0;
  logic       rs2use_ID = 1'b0;
  logic [4:0] rs1_ID = '0;
  logic [4:0] rs2_ID = '0;
  logic [4:0] rd_ID = '0;
  logic [1:0] hazard_optype_ID = '0;
  logic       Branch_ID = 1'b0;
  logic [1:0] forward_ctrl_A;
  logic [1:0] forward_ctrl_B;
  logic       forward_ctrl_ls;
  logic       PC_EN_IF;
  logic       reg_FD_EN;
  logic       reg_FD_flush;
  logic       reg_DE_flush;
  logic       reg_EM_EN;
  logic       reg_MW_EN;

  int checks = 0;
  int errors = 0;

  hazard_sched_unit dut (
    .clk              (clk),
    .rst              (rst),
    .mem_busy         (mem_busy),
    .rs1use_ID        (rs1use_ID),
    .rs2use_ID        (rs2use_ID),
    .rs1_ID           (rs1_ID),
    .rs2_ID           (rs2_ID),
    .rd_ID            (rd_ID),
    .hazard_optype_ID (hazard_optype_ID),
    .Branch_ID        (Branch_ID),
    .forward_ctrl_A   (forward_ctrl_A),
    .forward_ctrl_B   (forward_ctrl_B),
    .forward_ctrl_ls  (forward_ctrl_ls),
    .PC_EN_IF         (PC_EN_IF),
    .reg_FD_EN        (reg_FD_EN),
    .reg_FD_flush     (reg_FD_flush),
    .reg_DE_flush     (reg_DE_flush),
    .reg_EM_EN        (reg_EM_EN),
    .reg_MW_EN        (reg_MW_EN)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       r1u;
    logic       r2u;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [1:0] opt;
    logic       br;
  } in_t;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ls;
    logic       pc;
    logic       fden;
    logic       fdfl;
    logic       defl;
    logic       em;
    logic       mw;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  // One pipeline slot per instruction: its class, its destination
  // (x0 if it writes nothing), and whether its store data comes from WB.
  typedef struct {
    logic [1:0] opt;
    logic [4:0] rd;
    logic       ls;
  } slot_t;

  slot_t m_ex;
  slot_t m_mem;

  function automatic void m_reset();
    m_ex  = '{opt: 2'd0, rd: 5'd0, ls: 1'b0};
    m_mem = '{opt: 2'd0, rd: 5'd0, ls: 1'b0};
  endfunction

  function automatic logic [1:0] m_fwd(input logic u, input logic [4:0] rs);
    if (!u || rs == 5'd0) return 2'd0;
    if (m_ex.opt == 2'd1 && m_ex.rd == rs) return 2'd1;
    if (m_mem.opt == 2'd1 && m_mem.rd == rs) return 2'd2;
    if (m_mem.opt == 2'd2 && m_mem.rd == rs) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic m_stall(input in_t v);
    if (m_ex.opt != 2'd2 || m_ex.rd == 5'd0) return 1'b0;
    if (v.r1u && v.rs1 == m_ex.rd) return 1'b1;
    if (v.r2u && v.rs2 == m_ex.rd && v.opt != 2'd3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic out_t m_out(input in_t v);
    out_t o;
    logic s;
    s      = m_stall(v);
    o.fa   = m_fwd(v.r1u, v.rs1);
    o.fb   = m_fwd(v.r2u, v.rs2);
    o.ls   = m_mem.ls;
    o.pc   = !s && !v.busy;
    o.fden = !s && !v.busy;
    o.fdfl = v.br && !s && !v.busy;
    o.defl = s && !v.busy;
    o.em   = !v.busy;
    o.mw   = !v.busy;
    return o;
  endfunction

  function automatic void m_adv(input in_t v);
    slot_t nx;
    logic  s;
    if (v.busy) return;
    s = m_stall(v);
    if (s) begin
      nx = '{opt: 2'd0, rd: 5'd0, ls: 1'b0};
    end else begin
      nx.opt = v.opt;
      nx.rd  = (v.opt == 2'd1 || v.opt == 2'd2) ? v.rd : 5'd0;
      nx.ls  = v.opt == 2'd3 && m_ex.opt == 2'd2 && m_ex.rd != 5'd0
               && v.r2u && v.rs2 == m_ex.rd;
    end
    m_mem = m_ex;
    m_ex  = nx;
  endfunction

  function automatic out_t dut_out();
    out_t o;
    o.fa   = forward_ctrl_A;
    o.fb   = forward_ctrl_B;
    o.ls   = forward_ctrl_ls;
    o.pc   = PC_EN_IF;
    o.fden = reg_FD_EN;
    o.fdfl = reg_FD_flush;
    o.defl = reg_DE_flush;
    o.em   = reg_EM_EN;
    o.mw   = reg_MW_EN;
    return o;
  endfunction

  function automatic in_t mi(input logic r1u, input logic [4:0] rs1,
                             input logic r2u, input logic [4:0] rs2,
                             input logic [1:0] opt, input logic [4:0] rd,
                             input logic br);
    in_t v;
    v.busy = 1'b0;
    v.r1u  = r1u;
    v.rs1  = rs1;
    v.r2u  = r2u;
    v.rs2  = rs2;
    v.opt  = opt;
    v.rd   = rd;
    v.br   = br;
    return v;
  endfunction

  function automatic out_t mo(input logic [1:0] fa, input logic [1:0] fb,
                              input logic ls, input logic stall,
                              input logic fdfl);
    out_t o;
    o.fa   = fa;
    o.fb   = fb;
    o.ls   = ls;
    o.pc   = !stall;
    o.fden = !stall;
    o.fdfl = fdfl;
    o.defl = stall;
    o.em   = 1'b1;
    o.mw   = 1'b1;
    return o;
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got fa=%0d fb=%0d ls=%0b pc=%0b fden=%0b fdfl=%0b defl=%0b em=%0b mw=%0b, expected fa=%0d fb=%0d ls=%0b pc=%0b fden=%0b fdfl=%0b defl=%0b em=%0b mw=%0b",
               nm, act.fa, act.fb, act.ls, act.pc, act.fden, act.fdfl,
               act.defl, act.em, act.mw, exp.fa, exp.fb, exp.ls, exp.pc,
               exp.fden, exp.fdfl, exp.defl, exp.em, exp.mw);
    end
  endtask

  task automatic drive(input in_t v);
    mem_busy         = v.busy;
    rs1use_ID        = v.r1u;
    rs2use_ID        = v.r2u;
    rs1_ID           = v.rs1;
    rs2_ID           = v.rs2;
    rd_ID            = v.rd;
    hazard_optype_ID = v.opt;
    Branch_ID        = v.br;
  endtask

  // Called at a negedge; checks before the next posedge, then advances.
  task automatic step(input in_t v, input string nm,
                      input logic has_exp, input out_t exp);
    out_t act;
    drive(v);
    #1;
    act = dut_out();
    check({nm, "/model"}, act, m_out(v));
    if (has_exp) check(nm, act, exp);
    @(posedge clk);
    m_adv(v);
    @(negedge clk);
  endtask

  vec_t  tbl[$];
  in_t   v;
  out_t  frz;
  out_t  rst_exp;
  out_t  act;

  initial begin
    m_reset();
    tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 1, 5, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 5, 0, 0, 1, 8, 0), mo(1, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 5, 0, 0, 0, 0, 0), mo(2, 0, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 2, 6, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 1, 6, 1, 9, 0), mo(0, 0, 0, 1, 0)});
    tbl.push_back('{mi(0, 0, 1, 6, 1, 9, 0), mo(0, 3, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 2, 7, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 2, 1, 7, 3, 7, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 1), mo(0, 0, 1, 0, 1)});
    tbl.push_back('{mi(0, 0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 1, 0, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 0, 0, 0, 2, 0, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 0, 1, 0, 1, 3, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 2, 4, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 4, 0, 0, 0, 0, 1), mo(0, 0, 0, 1, 0)});
    tbl.push_back('{mi(1, 4, 0, 0, 0, 0, 1), mo(3, 0, 0, 0, 1)});
    tbl.push_back('{mi(1, 10, 0, 0, 1, 10, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 10, 0, 0, 1, 10, 0), mo(1, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 10, 1, 10, 0, 0, 0), mo(1, 1, 0, 0, 0)});
    tbl.push_back('{mi(0, 0, 0, 0, 2, 11, 0), mo(0, 0, 0, 0, 0)});
    tbl.push_back('{mi(1, 11, 1, 5, 3, 0, 0), mo(0, 0, 0, 1, 0)});
    tbl.push_back('{mi(1, 11, 1, 5, 3, 0, 0), mo(3, 0, 0, 0, 0)});

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) step(tbl[k].i, $sformatf("tbl%0d", k), 1'b1, tbl[k].o);

    // Freeze for 3 cycles with an ALU producer in EX.
    step(mi(0, 0, 0, 0, 1, 12, 0), "frz_setup", 1'b0, '0);
    frz = '{fa: 2'd1, fb: 2'd0, ls: 1'b0, pc: 1'b0, fden: 1'b0,
            fdfl: 1'b0, defl: 1'b0, em: 1'b0, mw: 1'b0};
    for (int k = 0; k < 3; k++) begin
      v = mi(1, 12, 0, 0, 2, 13, 1);
      v.busy = 1'b1;
      step(v, $sformatf("freeze%0d", k), 1'b1, frz);
    end
    step(mi(1, 12, 0, 0, 2, 13, 1), "unfreeze", 1'b1, mo(1, 0, 0, 0, 1));

    // Load x13 now in EX; freeze, then reset asynchronously mid-cycle.
    v = mi(1, 13, 0, 0, 0, 0, 0);
    v.busy = 1'b1;
    drive(v);
    #1;
    check("pre_rst", dut_out(), m_out(v));
    #1;
    rst = 1'b1;
    #1;
    m_reset();
    mem_busy = 1'b0;
    #1;
    rst_exp = '{fa: 2'd0, fb: 2'd0, ls: 1'b0, pc: 1'b1, fden: 1'b1,
                fdfl: 1'b0, defl: 1'b0, em: 1'b1, mw: 1'b1};
    act = dut_out();
    check("async_rst", act, rst_exp);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      v.busy = ($urandom_range(0, 4) == 0);
      v.r1u  = $urandom_range(0, 1) == 1;
      v.r2u  = $urandom_range(0, 1) == 1;
      v.rs1  = 5'($urandom_range(0, 3));
      v.rs2  = 5'($urandom_range(0, 3));
      v.rd   = 5'($urandom_range(0, 3));
      v.opt  = 2'($urandom_range(0, 3));
      v.br   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_reset();
      end
      step(v, "rand", 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
